kmer_mem_loader: RTL

Streaming writer for the packed sequence memory that k-mer fragment extraction reads. It accepts one 4-bit base per cycle over a valid/ready stream and packs it into an ACTUAL_MEM-slot register (base i at bits [i*BASE_LEN +: BASE_LEN]). It validates the base encoding, zero-pads unused slots as 'N', and holds the completed frame stable under a valid/ack handshake until the downstream extractor releases it.

---
 rtl/kmer_mem_loader.sv | 119 +++++++++++
 1 files changed

// File: rtl/kmer_mem_loader.sv
// Packs a stream of 4-bit one-hot bases into a fixed-size frame and presents
// the completed frame under a valid/ack handshake until the extractor releases it.
module kmer_mem_loader #(
    parameter int ACTUAL_MEM = 32,
    parameter int BASE_LEN   = 4,
    parameter int MEM_LEN    = ACTUAL_MEM * BASE_LEN,
    parameter int INDICE_LEN = $clog2(ACTUAL_MEM),
    parameter int CNT_LEN    = INDICE_LEN + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BASE_LEN-1:0] in_base,
    input  logic                in_last,
    output logic [MEM_LEN-1:0]  memory,
    output logic                mem_valid,
    input  logic                mem_ack,
    output logic [CNT_LEN-1:0]  base_count,
    output logic [CNT_LEN-1:0]  bad_count,
    output logic                truncated
);

    typedef enum logic [1:0] {
        FILL,
        DRAIN,
        HOLD
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [MEM_LEN-1:0]    r_memory;
    logic [INDICE_LEN-1:0] r_wr_ptr;
    logic [CNT_LEN-1:0]    r_base_count;
    logic [CNT_LEN-1:0]    r_bad_count;
    logic                  r_truncated;

    logic                  w_accept;
    logic                  w_legal;
    logic                  w_full;
    logic [BASE_LEN-1:0]   w_store;

    // Handshake outputs decode registered state only, so no input reaches them combinationally.
    assign in_ready   = (r_state != HOLD);
    assign mem_valid  = (r_state == HOLD);
    assign memory     = r_memory;
    assign base_count = r_base_count;
    assign bad_count  = r_bad_count;
    assign truncated  = r_truncated;

    assign w_accept = in_valid && in_ready;
    // Zero (N) or exactly one bit set is a legal encoding.
    assign w_legal  = (in_base & (in_base - BASE_LEN'(1))) == '0;
    assign w_store  = w_legal ? in_base : '0;
    assign w_full   = (r_wr_ptr == INDICE_LEN'(ACTUAL_MEM - 1));

    // NOTE: next-state is assigned a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FILL: begin
                if (w_accept) begin
                    if (in_last)     w_next_state = HOLD;
                    else if (w_full) w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (w_accept && in_last) w_next_state = HOLD;
            end
            HOLD: begin
                if (mem_ack) w_next_state = FILL;
            end
            default: w_next_state = FILL;
        endcase
    end

    // NOTE: all state uses non-blocking assignment; the frame is a flop register, so it is reset like any other state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FILL;
            r_memory     <= '0;
            r_wr_ptr     <= '0;
            r_base_count <= '0;
            r_bad_count  <= '0;
            r_truncated  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        for (int i = 0; i < ACTUAL_MEM; i++) begin
                            if (r_wr_ptr == INDICE_LEN'(i)) begin
                                r_memory[i*BASE_LEN +: BASE_LEN] <= w_store;
                            end
                        end
                        r_wr_ptr     <= r_wr_ptr + INDICE_LEN'(1);
                        r_base_count <= r_base_count + CNT_LEN'(1);
                        if (!w_legal) r_bad_count <= r_bad_count + CNT_LEN'(1);
                    end
                end
                DRAIN: begin
                    if (w_accept) r_truncated <= 1'b1;
                end
                HOLD: begin
                    // Clearing on release leaves every unwritten slot of the next frame as N.
                    if (mem_ack) begin
                        r_memory     <= '0;
                        r_wr_ptr     <= '0;
                        r_base_count <= '0;
                        r_bad_count  <= '0;
                        r_truncated  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
